spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
Sequencer that drives the byte-level SPI master engine to perform standard serial-flash READ transactions: opcode, 24-bit address, then N data bytes. It owns the engine's slave-select and start/done handshake and streams received bytes to a consumer with a valid/ready handshake. It sits between the CPU/boot loader and the SPI master, so software issues one request per block read instead of sequencing individual bytes.

Parameters:
READ_CMD, 8'h03, opcode sent as the first byte
CS_GAP, 2, minimum cycles o_sel stays low after a transaction before o_done and the return to IDLE (1..15)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_req  in  1  start request, sampled only in IDLE
i_addr  in  24  flash byte address, captured with i_req
i_len  in  8  byte count, captured with i_req; 0 means 256
i_abort  in  1  terminate current transaction early
o_busy  out  1  high from the cycle after an accepted i_req until o_done
o_done  out  1  one-cycle pulse at end of transaction
o_aborted  out  1  valid with o_done; 1 if ended by i_abort
o_data  out  8  received data byte
o_valid  out  1  o_data valid
i_ready  in  1  consumer accepts o_data when o_valid&i_ready
o_sel  out  1  slave select to engine, active-high
o_xfer_start  out  1  one-cycle pulse: engine shifts o_xfer_data
o_xfer_data  out  8  byte to transmit
i_xfer_busy  in  1  engine mid-byte
i_xfer_done  in  1  one-cycle pulse, byte complete
i_xfer_data  in  8  received byte, valid when i_xfer_done=1

Behaviour:
- Reset (async): state IDLE; all outputs 0; o_sel drops immediately, no CS_GAP wait; captured address/count cleared.
- States: IDLE, SETUP, CMD, A2, A1, A0, DATA, HOLD, GAP.
- IDLE: i_req=1 at edge N -> capture i_addr, i_len; SETUP; o_sel=1, o_busy=1 from N+1.
- SETUP: one cycle of select setup -> CMD.
- CMD/A2/A1/A0: on entry, when i_xfer_busy=0, pulse o_xfer_start with READ_CMD, addr[23:16], addr[15:8], addr[7:0] respectively; o_xfer_data held stable from start until i_xfer_done; advance on i_xfer_done. Received bytes ignored. First o_xfer_start is at cycle N+2.
- DATA: start with o_xfer_data=8'h00; on i_xfer_done latch i_xfer_data into o_data, decrement remaining count, go HOLD; o_valid=1 the next cycle.
- HOLD: o_valid, o_data stable until o_valid&i_ready. Same cycle: o_valid drops next edge; if remaining>0 -> DATA (next o_xfer_start is one cycle after acceptance), else GAP.
- Count: 9-bit internal; i_len=0 loads 256; exactly N data bytes are delivered, never N+1.
- GAP: o_sel=0 for CS_GAP cycles, then o_done=1 for one cycle with o_busy still 1; IDLE next cycle, o_busy=0.
- Never issue o_xfer_start while i_xfer_busy=1 or while an i_xfer_done is still outstanding.
- i_req while o_busy=1: ignored, not queued. i_req in the cycle o_done is high: ignored.
- i_abort (any non-IDLE state, sampled level): if a byte is in flight, wait for its i_xfer_done and discard that byte (no o_valid). In HOLD: drop o_valid without a handshake. Then GAP; o_done with o_aborted=1. In IDLE, i_abort has no effect.
- i_xfer_done outside an outstanding transfer: ignored.

Test Plan:
- Read addr 24'h123456, len 4, i_ready=1; engine model returns AA,BB,CC,DD -> MOSI bytes 03,12,34,56,00,00,00,00; o_valid for AA,BB,CC,DD in order; o_done once, o_aborted=0; o_sel low ≥2 cycles before o_done.
- len=0 -> exactly 256 data transfers and 256 o_valid handshakes; 260 o_xfer_start pulses total.
- Consumer backpressure: i_ready low 10 cycles per byte -> o_data stable while o_valid=1; no o_xfer_start until acceptance; no bytes lost.
- i_abort during the 2nd data byte -> that byte completes on the engine but is not presented; o_done with o_aborted=1; o_sel low.
- i_req pulsed while busy, and in the o_done cycle -> ignored; a later i_req in IDLE starts a clean transaction.
- Assert i_rst during A1 -> o_sel, o_busy, o_valid, o_xfer_start go 0 without waiting for an edge; after release, state is IDLE and the next i_req works.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: sequences a serial-flash READ (opcode, 24-bit address,
// N data bytes) over a byte-level SPI master engine and streams received
// bytes to a consumer through a valid/ready handshake.
module spi_flash_reader #(
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         CS_GAP   = 2      // 1..15 cycles of deselect before o_done
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // request side
    input  logic        i_req,
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_len,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_aborted,
    // received data stream
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    // byte engine
    output logic        o_sel,
    output logic        o_xfer_start,
    output logic [7:0]  o_xfer_data,
    input  logic        i_xfer_busy,
    input  logic        i_xfer_done,
    input  logic [7:0]  i_xfer_data
);

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        CMD,
        A2,
        A1,
        A0,
        DATA,
        HOLD,
        GAP
    } state_t;

    state_t      state;
    logic [23:0] addr;        // captured flash address
    logic [8:0]  remaining;   // data bytes still to fetch; 256 encodes i_len == 0
    logic [3:0]  gap_cnt;     // deselect cycles elapsed in GAP
    logic        in_flight;   // a byte we launched has not reported done yet
    logic        abort_pend;  // abort seen while a byte was in flight
    logic        aborted;     // transaction is ending because of i_abort
    logic [7:0]  tx_byte;     // byte to transmit for the current byte state

    // Byte to transmit in each byte-level state.
    always_comb begin
        // NOTE: give every combinational output a value before the case so
        // no path leaves it unassigned (otherwise a latch is inferred).
        tx_byte = 8'h00;
        case (state)
            CMD:     tx_byte = READ_CMD;
            A2:      tx_byte = addr[23:16];
            A1:      tx_byte = addr[15:8];
            A0:      tx_byte = addr[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    // Transaction sequencer; every output is a register driven from here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: state uses non-blocking assignments so every register in
            // this block sees the pre-edge values of all the others.
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            gap_cnt      <= '0;
            in_flight    <= 1'b0;
            abort_pend   <= 1'b0;
            aborted      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_sel        <= 1'b0;
            o_xfer_start <= 1'b0;
            o_xfer_data  <= '0;
        end else begin
            // start is a single-cycle pulse unless a launch below re-asserts it
            o_xfer_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_req) begin
                        addr       <= i_addr;
                        remaining  <= (i_len == 8'd0) ? 9'd256 : {1'b0, i_len};
                        in_flight  <= 1'b0;
                        abort_pend <= 1'b0;
                        aborted    <= 1'b0;
                        o_sel      <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    if (i_abort) begin
                        state      <= GAP;
                        o_sel      <= 1'b0;
                        gap_cnt    <= '0;
                        aborted    <= 1'b1;
                        abort_pend <= 1'b0;
                    end else begin
                        // launch the opcode on the same edge so it goes out
                        // right after the one-cycle select setup
                        state <= CMD;
                        if (!i_xfer_busy) begin
                            o_xfer_start <= 1'b1;
                            o_xfer_data  <= READ_CMD;
                            in_flight    <= 1'b1;
                        end
                    end
                end

                CMD, A2, A1, A0, DATA: begin
                    if (in_flight) begin
                        if (i_abort) begin
                            abort_pend <= 1'b1;
                        end
                        if (i_xfer_done) begin
                            in_flight <= 1'b0;
                            if (abort_pend || i_abort) begin
                                // the finished byte is dropped, never presented
                                state      <= GAP;
                                o_sel      <= 1'b0;
                                gap_cnt    <= '0;
                                aborted    <= 1'b1;
                                abort_pend <= 1'b0;
                            end else begin
                                case (state)
                                    CMD:     state <= A2;
                                    A2:      state <= A1;
                                    A1:      state <= A0;
                                    A0:      state <= DATA;
                                    default: begin
                                        o_data    <= i_xfer_data;
                                        o_valid   <= 1'b1;
                                        remaining <= remaining - 9'd1;
                                        state     <= HOLD;
                                    end
                                endcase
                            end
                        end
                    end else if (i_abort) begin
                        state      <= GAP;
                        o_sel      <= 1'b0;
                        gap_cnt    <= '0;
                        aborted    <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (!i_xfer_busy) begin
                        o_xfer_start <= 1'b1;
                        o_xfer_data  <= tx_byte;
                        in_flight    <= 1'b1;
                    end
                end

                HOLD: begin
                    if (i_abort) begin
                        // withdraw the byte without waiting for the consumer
                        o_valid    <= 1'b0;
                        state      <= GAP;
                        o_sel      <= 1'b0;
                        gap_cnt    <= '0;
                        aborted    <= 1'b1;
                        abort_pend <= 1'b0;
                    end else if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        if (remaining != 9'd0) begin
                            // next dummy byte goes out on the acceptance edge
                            state <= DATA;
                            if (!i_xfer_busy) begin
                                o_xfer_start <= 1'b1;
                                o_xfer_data  <= 8'h00;
                                in_flight    <= 1'b1;
                            end
                        end else begin
                            state      <= GAP;
                            o_sel      <= 1'b0;
                            gap_cnt    <= '0;
                            aborted    <= 1'b0;
                            abort_pend <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    if (o_done) begin
                        // the done cycle itself still counts as busy
                        o_done    <= 1'b0;
                        o_aborted <= 1'b0;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else if (gap_cnt == 4'(CS_GAP - 1)) begin
                        o_done    <= 1'b1;
                        o_aborted <= aborted;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    o_sel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: drives spi_flash_reader with a behavioural byte
// engine and consumer, and compares every transaction with a model of the
// expected MOSI byte stream and the delivered data bytes.
module tb_spi_flash_reader;

    localparam logic [7:0] READ_CMD = 8'h03;
    localparam int         CS_GAP   = 2;

    logic        i_clk       = 1'b0;
    logic        i_rst       = 1'b0;
    logic        i_req       = 1'b0;
    logic [23:0] i_addr      = '0;
    logic [7:0]  i_len       = '0;
    logic        i_abort     = 1'b0;
    logic        i_ready     = 1'b0;
    logic        i_xfer_busy = 1'b0;
    logic        i_xfer_done = 1'b0;
    logic [7:0]  i_xfer_data = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_sel;
    logic        o_xfer_start;
    logic [7:0]  o_xfer_data;

    spi_flash_reader #(
        .READ_CMD (READ_CMD),
        .CS_GAP   (CS_GAP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_len        (i_len),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_aborted    (o_aborted),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_sel        (o_sel),
        .o_xfer_start (o_xfer_start),
        .o_xfer_data  (o_xfer_data),
        .i_xfer_busy  (i_xfer_busy),
        .i_xfer_done  (i_xfer_done),
        .i_xfer_data  (i_xfer_data)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mosi_q[$];   // bytes the engine was asked to send
    logic [7:0] resp_q[$];   // byte the engine returned for each transfer
    logic [7:0] got_q[$];    // bytes the consumer accepted
    logic [7:0] force_q[$];  // optional fixed engine responses

    int         eng_cnt     = 0;
    logic [7:0] eng_data    = '0;
    int         ready_mode  = 0;   // 0: always ready, 1: random, 2: 10-cycle stall
    int         wait_cnt    = 0;
    bit         hold_active = 1'b0;
    logic [7:0] hold_data   = '0;
    int         start_viol  = 0;
    int         hold_viol   = 0;
    int         stab_viol   = 0;
    int         vstart_viol = 0;
    int         done_cnt    = 0;
    int         sel_low     = 0;
    int         last_gap    = 0;
    bit         last_abort  = 1'b0;
    bit         done_busy   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    // Expected MOSI byte at position idx of a READ transaction.
    function automatic logic [7:0] exp_mosi(input int idx, input logic [23:0] a);
        if (idx == 0) return READ_CMD;
        if (idx == 1) return a[23:16];
        if (idx == 2) return a[15:8];
        if (idx == 3) return a[7:0];
        return 8'h00;
    endfunction

    // Byte engine, consumer and protocol monitors, all evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge i_clk);
            // engine
            i_xfer_done = 1'b0;
            if (o_xfer_start) begin
                if (i_xfer_busy) start_viol++;
                mosi_q.push_back(o_xfer_data);
                if (force_q.size() > 0) eng_data = force_q.pop_front();
                else                    eng_data = 8'($urandom);
                resp_q.push_back(eng_data);
                eng_cnt     = int'($urandom_range(3, 6));
                i_xfer_busy = 1'b1;
                i_xfer_data = 8'($urandom);
            end else if (i_xfer_busy) begin
                if (o_busy && mosi_q.size() > 0 && o_xfer_data !== mosi_q[$]) hold_viol++;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    i_xfer_busy = 1'b0;
                    i_xfer_done = 1'b1;
                    i_xfer_data = eng_data;
                end else begin
                    i_xfer_data = 8'($urandom);
                end
            end else begin
                i_xfer_data = 8'($urandom);
            end
            // consumer
            case (ready_mode)
                0: i_ready = 1'b1;
                1: i_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (o_valid && wait_cnt >= 10) begin
                        i_ready = 1'b1;
                    end else begin
                        i_ready = 1'b0;
                        if (o_valid) wait_cnt++;
                        else         wait_cnt = 0;
                    end
                end
            endcase
            if (o_valid) begin
                if (hold_active && o_data !== hold_data) stab_viol++;
                if (o_xfer_start) vstart_viol++;
                hold_active = 1'b1;
                hold_data   = o_data;
                if (i_ready) begin
                    got_q.push_back(o_data);
                    hold_active = 1'b0;
                end
            end else begin
                hold_active = 1'b0;
            end
            // deselect and completion
            if (o_sel)                  sel_low = 0;
            else if (o_busy && !o_done) sel_low++;
            if (o_done) begin
                done_cnt++;
                last_gap   = sel_low;
                last_abort = o_aborted;
                done_busy  = o_busy;
            end
        end
    end

    task automatic clear_model();
        mosi_q.delete();
        resp_q.delete();
        got_q.delete();
        start_viol  = 0;
        hold_viol   = 0;
        stab_viol   = 0;
        vstart_viol = 0;
    endtask

    // One READ transaction plus every check derived from the request alone.
    task automatic run_txn(input logic [23:0] addr, input logic [7:0] len, input int rmode,
                           input int abort_at, input bit timing, input bit junk);
        int n;
        int exp_rx;
        int base_done;
        int cyc;
        logic [7:0] r;
        n      = (len == 8'd0) ? 256 : int'(len);
        exp_rx = (abort_at > 0) ? abort_at - 5 : n;
        clear_model();
        ready_mode = rmode;
        base_done  = done_cnt;
        i_addr = addr;
        i_len  = len;
        i_req  = 1'b1;
        tick();
        i_req  = 1'b0;
        i_addr = 24'($urandom);
        i_len  = 8'($urandom);
        check("busy_after_req", 32'(o_busy), 1);
        check("sel_after_req", 32'(o_sel), 1);
        if (timing) begin
            check("no_start_in_setup", 32'(o_xfer_start), 0);
            tick();
            check("first_start", 32'(o_xfer_start), 1);
        end
        cyc = 0;
        while (done_cnt == base_done && cyc < 20000) begin
            if (abort_at > 0 && mosi_q.size() >= abort_at) i_abort = 1'b1;
            i_req = junk && (cyc == 5 || cyc == 9);
            tick();
            cyc++;
        end
        check("done_seen", 32'(done_cnt - base_done), 1);
        // a request during the done cycle must be ignored
        i_req = junk;
        tick();
        i_req   = 1'b0;
        i_abort = 1'b0;
        check("busy_cleared", 32'(o_busy), 0);
        repeat (3) tick();
        check("stays_idle", 32'(o_busy), 0);
        check("single_done", 32'(done_cnt - base_done), 1);
        check("aborted_flag", 32'(last_abort), (abort_at > 0) ? 1 : 0);
        check("gap_cycles", 32'(last_gap), CS_GAP);
        check("busy_in_done", 32'(done_busy), 1);
        check("mosi_count", 32'(mosi_q.size()), (abort_at > 0) ? abort_at : n + 4);
        for (int i = 0; i < mosi_q.size(); i++)
            check("mosi_byte", 32'(mosi_q[i]), 32'(exp_mosi(i, addr)));
        check("rx_count", 32'(got_q.size()), exp_rx);
        for (int i = 0; i < got_q.size(); i++) begin
            r = (i + 4 < resp_q.size()) ? resp_q[i + 4] : 8'h00;
            check("rx_byte", 32'(got_q[i]), 32'(r));
        end
        check("start_while_busy", 32'(start_viol), 0);
        check("tx_data_held", 32'(hold_viol), 0);
        check("rx_data_stable", 32'(stab_viol), 0);
        check("start_while_valid", 32'(vstart_viol), 0);
    endtask

    initial begin
        int cyc;
        logic [7:0] t1_exp[4];
        logic [7:0] g;

        // reset state
        #1 i_rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(o_busy), 0);
        check("rst_sel", 32'(o_sel), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_aborted", 32'(o_aborted), 0);
        check("rst_start", 32'(o_xfer_start), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_xfer_data", 32'(o_xfer_data), 0);
        i_rst = 1'b0;
        repeat (3) tick();
        check("idle_no_busy", 32'(o_busy), 0);

        // fixed read of four bytes
        t1_exp  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        force_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_txn(24'h123456, 8'd4, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'h00;
            check("t1_rx", 32'(g), 32'(t1_exp[i]));
        end

        // random addresses and lengths with random backpressure
        for (int k = 0; k < 4; k++)
            run_txn(24'($urandom), 8'($urandom_range(1, 6)), 1, 0, 1'b1, 1'b0);

        // length 0 means 256 bytes
        run_txn(24'hABCDEF, 8'd0, 0, 0, 1'b1, 1'b0);

        // consumer stalls 10 cycles per byte
        run_txn(24'h00F00D, 8'd3, 2, 0, 1'b1, 1'b0);

        // abort while the second data byte is in flight
        run_txn(24'h0A0B0C, 8'd5, 0, 6, 1'b1, 1'b0);
        check("abort_sel_low", 32'(o_sel), 0);

        // requests while busy and in the done cycle, then a clean read
        run_txn(24'h777777, 8'd4, 1, 0, 1'b1, 1'b1);
        run_txn(24'h345678, 8'd2, 0, 0, 1'b1, 1'b0);

        // asynchronous reset while the A1 byte is on the wire
        clear_model();
        ready_mode = 0;
        i_addr = 24'h89ABCD;
        i_len  = 8'd4;
        i_req  = 1'b1;
        tick();
        i_req = 1'b0;
        cyc = 0;
        while (mosi_q.size() < 3 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("reach_a1", 32'(mosi_q.size()), 3);
        tick();
        check("sel_before_rst", 32'(o_sel), 1);
        check("busy_before_rst", 32'(o_busy), 1);
        #2 i_rst = 1'b1;
        #1;
        check("async_sel", 32'(o_sel), 0);
        check("async_busy", 32'(o_busy), 0);
        check("async_valid", 32'(o_valid), 0);
        check("async_start", 32'(o_xfer_start), 0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(o_busy), 0);
        check("post_rst_sel", 32'(o_sel), 0);
        run_txn(24'h654321, 8'd3, 1, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the design stops responding altogether.
    initial begin
        #600000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
